// File: rtl/pll_mode_pkg.sv
// Shared types, video-mode divider table and encoding helpers for the rPLL mode sequencer.
package pll_mode_pkg;

  typedef enum logic [1:0] {
    StResetPll = 2'd0,
    StWaitLock = 2'd1,
    StRun      = 2'd2,
    StFail     = 2'd3
  } state_e;

  localparam int unsigned NUM_MODES = 5;

  // Raw divider ratios for the 27 MHz reference.
  typedef struct packed {
    logic [5:0] idiv;
    logic [5:0] fbdiv;
    logic [5:0] odiv;
  } mode_div_t;

  // Values driven onto the rPLL dynamic select pins.
  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
  } pll_sel_t;

  localparam mode_div_t Mode480p    = '{idiv: 6'd2, fbdiv: 6'd13, odiv: 6'd4};
  localparam mode_div_t Mode720p    = '{idiv: 6'd3, fbdiv: 6'd54, odiv: 6'd2};
  localparam mode_div_t Mode1120x832 = '{idiv: 6'd4, fbdiv: 6'd56, odiv: 6'd2};
  localparam mode_div_t Mode1080p30 = '{idiv: 6'd4, fbdiv: 6'd60, odiv: 6'd2};
  localparam mode_div_t Mode1440p30 = '{idiv: 6'd1, fbdiv: 6'd42, odiv: 6'd2};

  // ODIV ratio to the rPLL ODSEL pin code; unsupported ratios fall back to divide-by-2.
  function automatic logic [5:0] odiv_to_odsel(logic [5:0] odiv);
    logic [5:0] code;
    case (odiv)
      6'd4:    code = 6'b111110;
      6'd8:    code = 6'b111100;
      default: code = 6'b111111;
    endcase
    return code;
  endfunction

  // Mode index to rPLL select pins; out-of-range indices map to 1080p30.
  function automatic pll_sel_t mode_to_sel(logic [2:0] mode);
    mode_div_t div;
    pll_sel_t  sel;
    case (mode)
      3'd0:    div = Mode480p;
      3'd1:    div = Mode720p;
      3'd2:    div = Mode1120x832;
      3'd4:    div = Mode1440p30;
      default: div = Mode1080p30;
    endcase
    sel.idsel  = ~div.idiv;
    sel.fbdsel = ~div.fbdiv;
    sel.odsel  = odiv_to_odsel(div.odiv);
    return sel;
  endfunction

endpackage

// File: rtl/pll_mode_sequencer_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous rPLL LOCK into the crystal clock domain.
module lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic lock_in,
  output logic lock_out
);

  logic meta_q;
  logic sync_q;

  // Plain two-stage shift; first stage may go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= lock_in;
      sync_q <= meta_q;
    end
  end

  assign lock_out = sync_q;

endmodule

// File: rtl/pll_mode_sequencer.sv
// Sequences rPLL reset, lock qualification and retry for the selected video mode, and holds
// the video domain in reset until the PLL output is stable.
module pll_mode_sequencer
  import pll_mode_pkg::*;
#(
  parameter int unsigned DEFAULT_MODE  = 3,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned LOCK_TIMEOUT  = 27000,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode_sel,
  input  logic       mode_req,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       video_rst,
  output logic [2:0] active_mode,
  output logic       locked,
  output logic       busy,
  output logic       fail,
  output logic       req_err
);

  localparam int unsigned RstW    = $clog2(RST_CYCLES);
  localparam int unsigned StableW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned ToW     = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned RetryW  = $clog2(MAX_RETRY + 2);
  localparam logic [2:0]  DefaultMode = 3'(DEFAULT_MODE);

  state_e             state_q, state_d;
  logic [2:0]         mode_q, mode_d;
  logic [RstW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [StableW-1:0] stable_q, stable_d;
  logic [ToW-1:0]     timeout_q, timeout_d;
  logic [RetryW-1:0]  retry_q, retry_d;
  logic               low_q, low_d;
  logic               pend_vld_q, pend_vld_d;
  logic [2:0]         pend_mode_q, pend_mode_d;

  logic               req_vld_q;
  logic [2:0]         req_mode_q;
  logic               req_err_q;

  logic               lock_s;
  logic               seq_start;
  logic [2:0]         seq_mode;
  pll_sel_t           sel;

  lock_sync u_lock_sync (
    .clk      (clk),
    .rst      (rst),
    .lock_in  (pll_lock),
    .lock_out (lock_s)
  );

  // Register the request strobe so range checking stays off the FSM path.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld_q  <= 1'b0;
      req_mode_q <= 3'd0;
      req_err_q  <= 1'b0;
    end else begin
      req_vld_q  <= mode_req && (mode_sel < 3'(NUM_MODES));
      req_err_q  <= mode_req && (mode_sel >= 3'(NUM_MODES));
      req_mode_q <= mode_sel;
    end
  end

  // Sequencer state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StResetPll;
      mode_q      <= DefaultMode;
      rst_cnt_q   <= '0;
      stable_q    <= '0;
      timeout_q   <= '0;
      retry_q     <= '0;
      low_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_mode_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rst_cnt_q   <= rst_cnt_d;
      stable_q    <= stable_d;
      timeout_q   <= timeout_d;
      retry_q     <= retry_d;
      low_q       <= low_d;
      pend_vld_q  <= pend_vld_d;
      pend_mode_q <= pend_mode_d;
    end
  end

  // Next-state logic: reset pulse, lock qualification, retry and request servicing.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rst_cnt_d   = rst_cnt_q;
    stable_d    = stable_q;
    timeout_d   = timeout_q;
    retry_d     = retry_q;
    low_d       = low_q;
    pend_vld_d  = pend_vld_q;
    pend_mode_d = pend_mode_q;
    seq_start   = 1'b0;
    seq_mode    = mode_q;

    unique case (state_q)
      StResetPll: begin
        if (req_vld_q) begin
          pend_vld_d  = 1'b1;
          pend_mode_d = req_mode_q;
        end
        if (rst_cnt_q == RstW'(RST_CYCLES - 1)) begin
          state_d   = StWaitLock;
          stable_d  = '0;
          timeout_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        if (req_vld_q) begin
          pend_vld_d  = 1'b1;
          pend_mode_d = req_mode_q;
        end
        // Stable completion is checked first so a simultaneous timeout still locks.
        if (stable_q == StableW'(STABLE_CYCLES)) begin
          state_d = StRun;
          low_d   = 1'b0;
        end else if (timeout_q == ToW'(LOCK_TIMEOUT)) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_q >= RetryW'(MAX_RETRY)) ? StFail : StResetPll;
        end else begin
          timeout_d = timeout_q + 1'b1;
          stable_d  = lock_s ? stable_q + 1'b1 : '0;
        end
      end
      StRun: begin
        retry_d = '0;
        if (req_vld_q) begin
          seq_start = 1'b1;
          seq_mode  = req_mode_q;
        end else if (pend_vld_q) begin
          seq_start = 1'b1;
          seq_mode  = pend_mode_q;
        end else if (!lock_s) begin
          if (low_q) begin
            state_d = StResetPll;
          end else begin
            low_d = 1'b1;
          end
        end else begin
          low_d = 1'b0;
        end
      end
      StFail: begin
        if (req_vld_q) begin
          seq_start = 1'b1;
          seq_mode  = req_mode_q;
        end else if (pend_vld_q) begin
          seq_start = 1'b1;
          seq_mode  = pend_mode_q;
        end
      end
    endcase

    // A served request loads the new dividers on the same edge RESET_PLL is entered.
    if (seq_start) begin
      state_d    = StResetPll;
      mode_d     = seq_mode;
      retry_d    = '0;
      pend_vld_d = 1'b0;
    end
    if (state_d == StResetPll && state_q != StResetPll) begin
      rst_cnt_d = '0;
    end
  end

  // Decode status outputs and divider pins from the registered state and mode.
  always_comb begin
    sel         = mode_to_sel(mode_q);
    pll_idsel   = sel.idsel;
    pll_fbdsel  = sel.fbdsel;
    pll_odsel   = sel.odsel;
    pll_reset   = (state_q == StResetPll) || (state_q == StFail);
    video_rst   = (state_q != StRun);
    locked      = (state_q == StRun);
    busy        = (state_q == StResetPll) || (state_q == StWaitLock);
    fail        = (state_q == StFail);
    active_mode = mode_q;
    req_err     = req_err_q;
  end

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Directed bench for pll_mode_sequencer with shortened sequencing constants.
module tb_pll_mode_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] mode_sel;
  logic       mode_req;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;
  logic       video_rst;
  logic [2:0] active_mode;
  logic       locked;
  logic       busy;
  logic       fail;
  logic       req_err;

  int checks;
  int errors;

  pll_mode_sequencer #(
    .DEFAULT_MODE  (3),
    .RST_CYCLES    (4),
    .STABLE_CYCLES (8),
    .LOCK_TIMEOUT  (64),
    .MAX_RETRY     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_sel    (mode_sel),
    .mode_req    (mode_req),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .pll_idsel   (pll_idsel),
    .pll_fbdsel  (pll_fbdsel),
    .pll_odsel   (pll_odsel),
    .video_rst   (video_rst),
    .active_mode (active_mode),
    .locked      (locked),
    .busy        (busy),
    .fail        (fail),
    .req_err     (req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_locked(input string name, input int limit);
    int n;
    n = 0;
    while (locked !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL %s: locked=%b after %0d cycles, required 1", name, locked, n);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; mode_req = 1'b0; mode_sel = 3'd0; pll_lock = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (pll_idsel !== 6'b111011 || pll_fbdsel !== 6'b000011 || pll_odsel !== 6'b111111) begin
      errors++;
      $display("FAIL reset_dividers: got %b/%b/%b required 111011/000011/111111",
               pll_idsel, pll_fbdsel, pll_odsel);
    end
    checks++;
    if ({pll_reset, video_rst, busy, locked, fail, req_err} !== 6'b111000) begin
      errors++;
      $display("FAIL reset_flags: rst/vrst/busy/lock/fail/err=%b required 111000",
               {pll_reset, video_rst, busy, locked, fail, req_err});
    end
    checks++;
    if (active_mode !== 3'd3) begin
      errors++;
      $display("FAIL reset_mode: got %0d required 3", active_mode);
    end
    rst = 1'b0;
    n = 0;
    while (pll_reset === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL reset_pulse_len: got %0d cycles required 4", n);
    end
    pll_lock = 1'b1;
    n = 0;
    while (locked !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 11) begin
      errors++;
      $display("FAIL lock_latency: got %0d cycles required 11", n);
    end
    checks++;
    if (video_rst !== 1'b0 || busy !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL run_flags: vrst/busy/fail=%b%b%b required 000", video_rst, busy, fail);
    end
  endtask

  task automatic test_mode_change();
    int n;
    mode_req = 1'b1; mode_sel = 3'd0;
    tick();
    mode_req = 1'b0;
    checks++;
    if (pll_idsel !== 6'b111011 || pll_reset !== 1'b0 || req_err !== 1'b0) begin
      errors++;
      $display("FAIL req_edge_n: idsel=%b reset=%b err=%b required 111011/0/0",
               pll_idsel, pll_reset, req_err);
    end
    tick();
    checks++;
    if (pll_idsel !== 6'b111101 || pll_fbdsel !== 6'b110010 || pll_odsel !== 6'b111110) begin
      errors++;
      $display("FAIL mode0_dividers: got %b/%b/%b required 111101/110010/111110",
               pll_idsel, pll_fbdsel, pll_odsel);
    end
    checks++;
    if (pll_reset !== 1'b1 || video_rst !== 1'b1 || active_mode !== 3'd0) begin
      errors++;
      $display("FAIL mode0_reset: reset=%b vrst=%b mode=%0d required 1/1/0",
               pll_reset, video_rst, active_mode);
    end
    n = 0;
    while (locked !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n != 13) begin
      errors++;
      $display("FAIL relock_latency: got %0d cycles required 13", n);
    end
  endtask

  task automatic test_lock_drop();
    int dropped;
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    dropped = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (locked !== 1'b1 || video_rst !== 1'b0) dropped++;
    end
    checks++;
    if (dropped != 0) begin
      errors++;
      $display("FAIL glitch1_ignored: %0d bad cycles required 0", dropped);
    end
    pll_lock = 1'b0;
    tick();
    tick();
    pll_lock = 1'b1;
    tick();
    checks++;
    if (video_rst !== 1'b0) begin
      errors++;
      $display("FAIL drop2_early: video_rst=%b required 0", video_rst);
    end
    tick();
    checks++;
    if (video_rst !== 1'b1 || pll_reset !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL drop2_reseq: vrst=%b reset=%b locked=%b required 1/1/0",
               video_rst, pll_reset, locked);
    end
    wait_locked("drop2_relock", 60);
  endtask

  task automatic test_timeout_fail();
    int n, wait_len, rst_len, pulses, timeouts, bad;
    bit prev_wait;
    pll_lock = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if (pll_reset !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL loss_reset: reset=%b locked=%b required 1/0", pll_reset, locked);
    end
    prev_wait = 1'b0; wait_len = 0; rst_len = 1; pulses = 0; timeouts = 0; bad = 0; n = 0;
    while (fail !== 1'b1 && n < 600) begin
      tick();
      n++;
      if (pll_reset === 1'b1) begin
        if (prev_wait) begin
          timeouts++;
          if (wait_len != 65) bad++;
          wait_len = 0;
          rst_len = 0;
        end
        rst_len++;
        prev_wait = 1'b0;
      end else begin
        if (!prev_wait) begin
          pulses++;
          if (rst_len != 4) bad++;
        end
        wait_len++;
        prev_wait = 1'b1;
      end
    end
    checks++;
    if (fail !== 1'b1 || timeouts != 3 || pulses != 3 || bad != 0) begin
      errors++;
      $display("FAIL retry_to_fail: fail=%b timeouts=%0d pulses=%0d bad=%0d required 1/3/3/0",
               fail, timeouts, pulses, bad);
    end
    checks++;
    if ({pll_reset, video_rst, busy, locked} !== 4'b1100) begin
      errors++;
      $display("FAIL fail_flags: reset/vrst/busy/locked=%b required 1100",
               {pll_reset, video_rst, busy, locked});
    end
    mode_req = 1'b1; mode_sel = 3'd6;
    tick();
    mode_req = 1'b0;
    checks++;
    if (req_err !== 1'b1 || fail !== 1'b1) begin
      errors++;
      $display("FAIL bad_req_pulse: req_err=%b fail=%b required 1/1", req_err, fail);
    end
    tick();
    checks++;
    if (req_err !== 1'b0 || fail !== 1'b1) begin
      errors++;
      $display("FAIL bad_req_ignored: req_err=%b fail=%b required 0/1", req_err, fail);
    end
    mode_req = 1'b1; mode_sel = 3'd2;
    tick();
    mode_req = 1'b0;
    tick();
    checks++;
    if (fail !== 1'b0 || pll_reset !== 1'b1 || active_mode !== 3'd2) begin
      errors++;
      $display("FAIL fail_exit: fail=%b reset=%b mode=%0d required 0/1/2",
               fail, pll_reset, active_mode);
    end
    checks++;
    if (pll_idsel !== 6'b111011 || pll_fbdsel !== 6'b000111 || pll_odsel !== 6'b111111) begin
      errors++;
      $display("FAIL mode2_dividers: got %b/%b/%b required 111011/000111/111111",
               pll_idsel, pll_fbdsel, pll_odsel);
    end
  endtask

  task automatic test_lock_glitch();
    int n, ph;
    bit prev_wait, timed_out, saw_locked;
    prev_wait = 1'b0; timed_out = 1'b0; saw_locked = 1'b0; n = 0; ph = 0;
    while (!timed_out && n < 300) begin
      pll_lock = (ph % 5 != 4);
      tick();
      ph++;
      n++;
      if (locked === 1'b1) saw_locked = 1'b1;
      if (prev_wait && pll_reset === 1'b1) timed_out = 1'b1;
      prev_wait = (busy === 1'b1 && pll_reset === 1'b0);
    end
    pll_lock = 1'b1;
    checks++;
    if (!timed_out || saw_locked) begin
      errors++;
      $display("FAIL glitch_timeout: timed_out=%b saw_locked=%b required 1/0",
               timed_out, saw_locked);
    end
  endtask

  task automatic test_pending();
    int n;
    n = 0;
    while (!(busy === 1'b1 && pll_reset === 1'b0) && n < 20) begin
      tick();
      n++;
    end
    mode_req = 1'b1; mode_sel = 3'd1;
    tick();
    mode_sel = 3'd4;
    tick();
    mode_req = 1'b0;
    checks++;
    if (active_mode !== 3'd2 || pll_reset !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pend_no_change: mode=%0d reset=%b busy=%b required 2/0/1",
               active_mode, pll_reset, busy);
    end
    n = 0;
    while (locked !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL pend_lock_latency: got %0d cycles required 7", n);
    end
    tick();
    checks++;
    if (locked !== 1'b0 || pll_reset !== 1'b1 || active_mode !== 3'd4) begin
      errors++;
      $display("FAIL pend_served: locked=%b reset=%b mode=%0d required 0/1/4",
               locked, pll_reset, active_mode);
    end
    checks++;
    if (pll_idsel !== 6'b111110 || pll_fbdsel !== 6'b010101 || pll_odsel !== 6'b111111) begin
      errors++;
      $display("FAIL mode4_dividers: got %b/%b/%b required 111110/010101/111111",
               pll_idsel, pll_fbdsel, pll_odsel);
    end
    wait_locked("pend_relock", 60);
    tick(); tick(); tick();
    checks++;
    if (locked !== 1'b1 || active_mode !== 3'd4) begin
      errors++;
      $display("FAIL pend_cleared: locked=%b mode=%0d required 1/4", locked, active_mode);
    end
    mode_req = 1'b1; mode_sel = 3'd6;
    tick();
    mode_req = 1'b0;
    checks++;
    if (req_err !== 1'b1) begin
      errors++;
      $display("FAIL run_bad_req: req_err=%b required 1", req_err);
    end
    tick();
    checks++;
    if (req_err !== 1'b0 || locked !== 1'b1 || active_mode !== 3'd4) begin
      errors++;
      $display("FAIL run_bad_ignored: err=%b locked=%b mode=%0d required 0/1/4",
               req_err, locked, active_mode);
    end
  endtask

  task automatic test_back_to_back();
    mode_req = 1'b1; mode_sel = 3'd0;
    tick();
    mode_req = 1'b0;
    tick();
    checks++;
    if (active_mode !== 3'd0 || pll_reset !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: mode=%0d reset=%b required 0/1", active_mode, pll_reset);
    end
    mode_req = 1'b1; mode_sel = 3'd1;
    tick();
    mode_req = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (active_mode !== 3'd3 || pll_idsel !== 6'b111011 || pll_reset !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst: mode=%0d idsel=%b reset=%b required 3/111011/1",
               active_mode, pll_idsel, pll_reset);
    end
    wait_locked("mid_rst_lock", 60);
    tick(); tick();
    checks++;
    if (locked !== 1'b1 || active_mode !== 3'd3) begin
      errors++;
      $display("FAIL mid_rst_pend_dropped: locked=%b mode=%0d required 1/3", locked, active_mode);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    mode_req = 1'b0;
    mode_sel = 3'd0;
    pll_lock = 1'b0;
    test_reset();
    test_mode_change();
    test_lock_drop();
    test_timeout_fail();
    test_lock_glitch();
    test_pending();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
